// File: rtl/axis_header_stripper_pkg.sv
// ----------------------------------------------------------------------------
// axis_header_stripper_pkg: shared types and width helpers for the stripper.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package axis_header_stripper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2,
    ST_TAIL = 2'd3
  } state_t;

  function automatic int cnt_width(input int bytes);
    return $clog2(bytes + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_header_stripper_if.sv
// ----------------------------------------------------------------------------
// axis_header_stripper_if: length, packet, header and payload AXI-Stream links.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface axis_header_stripper_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CNT_WD       = $clog2(DATA_BYTE_WD + 1)
);
  logic                    s00_axis_tvalid;
  logic [CNT_WD-1:0]       s00_axis_tdata;
  logic                    s00_axis_tready;
  logic                    s01_axis_tvalid;
  logic [DATA_WD-1:0]      s01_axis_tdata;
  logic [DATA_BYTE_WD-1:0] s01_axis_tkeep;
  logic                    s01_axis_tlast;
  logic                    s01_axis_tready;
  logic                    m00_axis_tvalid;
  logic [DATA_WD-1:0]      m00_axis_tdata;
  logic [DATA_BYTE_WD-1:0] m00_axis_tkeep;
  logic                    m00_axis_tready;
  logic                    m01_axis_tvalid;
  logic [DATA_WD-1:0]      m01_axis_tdata;
  logic [DATA_BYTE_WD-1:0] m01_axis_tkeep;
  logic                    m01_axis_tlast;
  logic                    m01_axis_tready;

  // The stripper itself sits on the slave side of this bundle.
  modport slave (
    input  s00_axis_tvalid, s00_axis_tdata,
    output s00_axis_tready,
    input  s01_axis_tvalid, s01_axis_tdata, s01_axis_tkeep, s01_axis_tlast,
    output s01_axis_tready,
    output m00_axis_tvalid, m00_axis_tdata, m00_axis_tkeep,
    input  m00_axis_tready,
    output m01_axis_tvalid, m01_axis_tdata, m01_axis_tkeep, m01_axis_tlast,
    input  m01_axis_tready
  );

  modport master (
    output s00_axis_tvalid, s00_axis_tdata,
    input  s00_axis_tready,
    output s01_axis_tvalid, s01_axis_tdata, s01_axis_tkeep, s01_axis_tlast,
    input  s01_axis_tready,
    input  m00_axis_tvalid, m00_axis_tdata, m00_axis_tkeep,
    output m00_axis_tready,
    input  m01_axis_tvalid, m01_axis_tdata, m01_axis_tkeep, m01_axis_tlast,
    output m01_axis_tready
  );
endinterface

`default_nettype wire

// File: rtl/axis_header_stripper_keep_count.sv
// ----------------------------------------------------------------------------
// axis_header_stripper_keep_count: number of valid bytes in a contiguous keep.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axis_header_stripper_keep_count #(
  parameter int BYTES  = 4,
  parameter int CNT_WD = $clog2(BYTES + 1)
) (
  input  logic [BYTES-1:0]  keep,
  output logic [CNT_WD-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < BYTES; i++) begin
      count = count + CNT_WD'(keep[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_header_stripper.sv
// ----------------------------------------------------------------------------
// axis_header_stripper: splits the first N bytes of a packet onto a header
// stream and re-packs the remaining payload MSB-first. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axis_header_stripper
  import axis_header_stripper_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CNT_WD       = cnt_width(DATA_BYTE_WD)
) (
  input  logic                   clk,
  input  logic                   rst,
  axis_header_stripper_if.slave  bus,
  output logic                   err_short
);

  localparam int                W     = DATA_BYTE_WD;
  localparam logic [CNT_WD-1:0] W_CNT = CNT_WD'(W);
  localparam logic [W-1:0]      ONES  = {W{1'b1}};

  state_t             state, state_nxt;
  logic [CNT_WD-1:0]  hdr_len, res_cnt, len_in, beat_cnt;
  logic [DATA_WD-1:0] res, body_data;
  logic [W-1:0]       res_keep;
  logic               len_load, res_load, err_nxt;
  logic               s00_ready, s01_ready, s01_fire, m00_free, m01_free;
  logic               m00_valid, m00_load;
  logic [DATA_WD-1:0] m00_data, m00_data_nxt;
  logic [W-1:0]       m00_keep, m00_keep_nxt;
  logic               m01_valid, m01_load, m01_last, m01_last_nxt;
  logic [DATA_WD-1:0] m01_data, m01_data_nxt;
  logic [W-1:0]       m01_keep, m01_keep_nxt;
  int                 sum;

  axis_header_stripper_keep_count #(.BYTES(W), .CNT_WD(CNT_WD)) u_keep_count (
    .keep  (bus.s01_axis_tkeep),
    .count (beat_cnt)
  );

  assign len_in    = (bus.s00_axis_tdata > W_CNT) ? W_CNT : bus.s00_axis_tdata;
  assign m00_free  = !m00_valid || bus.m00_axis_tready;
  assign m01_free  = !m01_valid || bus.m01_axis_tready;
  assign s01_fire  = bus.s01_axis_tvalid && s01_ready;
  assign sum       = int'(res_cnt) + int'(beat_cnt);
  // The residual's tail bytes lead; a shift of a full width yields zero.
  assign body_data = (res << (8 * (W - int'(res_cnt)))) |
                     (bus.s01_axis_tdata >> (8 * int'(res_cnt)));

  always_comb begin
    state_nxt    = state;
    s00_ready    = 1'b0;
    s01_ready    = 1'b0;
    len_load     = 1'b0;
    res_load     = 1'b0;
    err_nxt      = 1'b0;
    m00_load     = 1'b0;
    m00_data_nxt = '0;
    m00_keep_nxt = '0;
    m01_load     = 1'b0;
    m01_data_nxt = '0;
    m01_keep_nxt = '0;
    m01_last_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        s00_ready = 1'b1;
        if (bus.s00_axis_tvalid) begin
          len_load  = 1'b1;
          state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        s01_ready = m00_free && m01_free;
        if (s01_fire) begin
          if (hdr_len == '0) begin
            m01_load     = 1'b1;
            m01_data_nxt = bus.s01_axis_tdata;
            m01_keep_nxt = bus.s01_axis_tkeep;
            m01_last_nxt = bus.s01_axis_tlast;
            state_nxt    = bus.s01_axis_tlast ? ST_IDLE : ST_BODY;
          end else if (beat_cnt < hdr_len) begin
            m00_load     = 1'b1;
            m00_data_nxt = bus.s01_axis_tdata >> (8 * (W - int'(beat_cnt)));
            m00_keep_nxt = ~(ONES << beat_cnt);
            err_nxt      = 1'b1;
            state_nxt    = ST_IDLE;
          end else begin
            m00_load     = 1'b1;
            m00_data_nxt = bus.s01_axis_tdata >> (8 * (W - int'(hdr_len)));
            m00_keep_nxt = ~(ONES << hdr_len);
            res_load     = 1'b1;
            if (bus.s01_axis_tlast) begin
              m01_load     = beat_cnt > hdr_len;
              m01_data_nxt = bus.s01_axis_tdata << (8 * int'(hdr_len));
              m01_keep_nxt = bus.s01_axis_tkeep << hdr_len;
              m01_last_nxt = 1'b1;
              state_nxt    = ST_IDLE;
            end else begin
              state_nxt = ST_BODY;
            end
          end
        end
      end
      ST_BODY: begin
        s01_ready = m01_free;
        if (s01_fire) begin
          m01_load     = 1'b1;
          m01_data_nxt = body_data;
          m01_keep_nxt = ONES;
          res_load     = 1'b1;
          if (bus.s01_axis_tlast) begin
            if (sum <= W) begin
              m01_keep_nxt = ONES << (W - sum);
              m01_last_nxt = 1'b1;
              state_nxt    = ST_IDLE;
            end else begin
              state_nxt = ST_TAIL;
            end
          end
        end
      end
      ST_TAIL: begin
        if (m01_free) begin
          m01_load     = 1'b1;
          m01_data_nxt = res << (8 * int'(hdr_len));
          m01_keep_nxt = res_keep << hdr_len;
          m01_last_nxt = 1'b1;
          state_nxt    = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hdr_len   <= '0;
      res_cnt   <= '0;
      res       <= '0;
      res_keep  <= '0;
      err_short <= 1'b0;
      m00_valid <= 1'b0;
      m00_data  <= '0;
      m00_keep  <= '0;
      m01_valid <= 1'b0;
      m01_data  <= '0;
      m01_keep  <= '0;
      m01_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      err_short <= err_nxt;
      if (len_load) begin
        hdr_len <= len_in;
        // N=0 behaves as pass-through in BODY, same as N=W.
        res_cnt <= (len_in == '0) ? '0 : W_CNT - len_in;
      end
      if (res_load) begin
        res      <= bus.s01_axis_tdata;
        res_keep <= bus.s01_axis_tkeep;
      end
      if (m00_load) begin
        m00_valid <= 1'b1;
        m00_data  <= m00_data_nxt;
        m00_keep  <= m00_keep_nxt;
      end else if (bus.m00_axis_tready) begin
        m00_valid <= 1'b0;
      end
      if (m01_load) begin
        m01_valid <= 1'b1;
        m01_data  <= m01_data_nxt;
        m01_keep  <= m01_keep_nxt;
        m01_last  <= m01_last_nxt;
      end else if (bus.m01_axis_tready) begin
        m01_valid <= 1'b0;
      end
    end
  end

  assign bus.s00_axis_tready = s00_ready;
  assign bus.s01_axis_tready = s01_ready;
  assign bus.m00_axis_tvalid = m00_valid;
  assign bus.m00_axis_tdata  = m00_data;
  assign bus.m00_axis_tkeep  = m00_keep;
  assign bus.m01_axis_tvalid = m01_valid;
  assign bus.m01_axis_tdata  = m01_data;
  assign bus.m01_axis_tkeep  = m01_keep;
  assign bus.m01_axis_tlast  = m01_last;

endmodule

`default_nettype wire

// File: tb/tb_axis_header_stripper.sv
// ----------------------------------------------------------------------------
// tb_axis_header_stripper: directed scoreboard bench for axis_header_stripper.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_axis_header_stripper;

  localparam int DATA_WD = 32;
  localparam int W       = 4;
  localparam int CNT_WD  = 3;

  typedef struct packed {
    logic [DATA_WD-1:0] d;
    logic [W-1:0]       k;
  } hdr_t;

  typedef struct packed {
    logic [DATA_WD-1:0] d;
    logic [W-1:0]       k;
    logic               l;
  } pay_t;

  logic clk = 1'b0;
  logic rst;
  logic err_short;
  int   checks = 0;
  int   fails  = 0;
  int   exp_err = 0;
  int   stall_en = 0;
  int   m01_block = 0;
  hdr_t exp0[$];
  pay_t exp1[$];

  always #5 clk = ~clk;

  axis_header_stripper_if #(.DATA_WD(DATA_WD)) bus ();

  axis_header_stripper #(.DATA_WD(DATA_WD)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_short (err_short)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic e0(input logic [31:0] d, input logic [3:0] k);
    exp0.push_back('{d: d, k: k});
  endtask

  task automatic e1(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp1.push_back('{d: d, k: k, l: l});
  endtask

  task automatic send_len(input int n);
    int t;
    bus.s00_axis_tvalid = 1'b1;
    bus.s00_axis_tdata  = CNT_WD'(n);
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.s00_axis_tready && t < 200);
    if (!bus.s00_axis_tready) chk("s00_timeout", 64'(bus.s00_axis_tready), 64'(1));
    @(posedge clk); #1;
    bus.s00_axis_tvalid = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int t;
    bus.s01_axis_tvalid = 1'b1;
    bus.s01_axis_tdata  = d;
    bus.s01_axis_tkeep  = k;
    bus.s01_axis_tlast  = l;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.s01_axis_tready && t < 200);
    if (!bus.s01_axis_tready) chk("s01_timeout", 64'(bus.s01_axis_tready), 64'(1));
    @(posedge clk); #1;
    bus.s01_axis_tvalid = 1'b0;
  endtask

  task automatic pkt_two_beat();
    send_len(2);
    e0(32'h0000AABB, 4'h3);
    e1(32'hCCDD1122, 4'hF, 1'b0);
    e1(32'h33440000, 4'hC, 1'b1);
    beat(32'hAABBCCDD, 4'hF, 1'b0);
    beat(32'h11223344, 4'hF, 1'b1);
  endtask

  // Output-side ready generator
  initial begin
    bus.m00_axis_tready = 1'b1;
    bus.m01_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.m00_axis_tready = (stall_en != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (m01_block > 0) begin
        m01_block--;
        bus.m01_axis_tready = 1'b0;
      end else begin
        bus.m01_axis_tready = (stall_en != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: pops and compares whenever an output handshake is about to occur
  initial begin : monitor
    logic  p_stall;
    pay_t  p_val;
    hdr_t  h;
    pay_t  p;
    p_stall = 1'b0;
    p_val   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_stall = 1'b0;
      end else begin
        if (p_stall)
          chk("m01_hold", 64'({bus.m01_axis_tvalid, bus.m01_axis_tdata, bus.m01_axis_tkeep,
              bus.m01_axis_tlast}), 64'({1'b1, p_val}));
        if (bus.m01_axis_tvalid && !bus.m01_axis_tready)
          chk("s01_ready_while_full", 64'(bus.s01_axis_tready), 64'(0));
        p_stall = bus.m01_axis_tvalid && !bus.m01_axis_tready;
        p_val   = '{d: bus.m01_axis_tdata, k: bus.m01_axis_tkeep, l: bus.m01_axis_tlast};
        if (bus.m00_axis_tvalid && bus.m00_axis_tready) begin
          if (exp0.size() == 0) begin
            chk("m00_unexpected", 64'(bus.m00_axis_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            h = exp0.pop_front();
            chk("m00_data", 64'(bus.m00_axis_tdata), 64'(h.d));
            chk("m00_keep", 64'(bus.m00_axis_tkeep), 64'(h.k));
          end
        end
        if (bus.m01_axis_tvalid && bus.m01_axis_tready) begin
          if (exp1.size() == 0) begin
            chk("m01_unexpected", 64'(bus.m01_axis_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            p = exp1.pop_front();
            chk("m01_data", 64'(bus.m01_axis_tdata), 64'(p.d));
            chk("m01_keep", 64'(bus.m01_axis_tkeep), 64'(p.k));
            chk("m01_last", 64'(bus.m01_axis_tlast), 64'(p.l));
          end
        end
        if (err_short) begin
          chk("err_short_expected", 64'(exp_err > 0), 64'(1));
          if (exp_err > 0) exp_err--;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.s00_axis_tvalid = 1'b0;
    bus.s00_axis_tdata  = '0;
    bus.s01_axis_tvalid = 1'b0;
    bus.s01_axis_tdata  = '0;
    bus.s01_axis_tkeep  = '0;
    bus.s01_axis_tlast  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m00_valid", 64'(bus.m00_axis_tvalid), 64'(0));
    chk("rst_m01_valid", 64'(bus.m01_axis_tvalid), 64'(0));
    chk("rst_err_short", 64'(err_short), 64'(0));
    chk("rst_s00_ready", 64'(bus.s00_axis_tready), 64'(1));
    chk("rst_s01_ready", 64'(bus.s01_axis_tready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Two-beat packet with a tail beat
    pkt_two_beat();

    // Short last beat fits into one payload beat
    send_len(2);
    e0(32'h0000AABB, 4'h3);
    e1(32'hCCDD1122, 4'hF, 1'b1);
    beat(32'hAABBCCDD, 4'hF, 1'b0);
    beat(32'h1122EEFF, 4'hC, 1'b1);

    // N=W: payload passes unchanged
    send_len(4);
    e0(32'h01020304, 4'hF);
    e1(32'h05060708, 4'hF, 1'b0);
    e1(32'h090AEEFF, 4'hC, 1'b1);
    beat(32'h01020304, 4'hF, 1'b0);
    beat(32'h05060708, 4'hF, 1'b0);
    beat(32'h090AEEFF, 4'hC, 1'b1);

    // N=0: no header, pass-through
    send_len(0);
    e1(32'h12345678, 4'hF, 1'b0);
    e1(32'h9ABC0000, 4'hC, 1'b1);
    beat(32'h12345678, 4'hF, 1'b0);
    beat(32'h9ABC0000, 4'hC, 1'b1);

    // Packet shorter than N
    send_len(3);
    e0(32'h0000AABB, 4'h3);
    exp_err++;
    beat(32'hAABBEEFF, 4'hC, 1'b1);

    // Single beat, header plus payload
    send_len(1);
    e0(32'h00000011, 4'h1);
    e1(32'h22334400, 4'hE, 1'b1);
    beat(32'h11223344, 4'hF, 1'b1);

    // Single beat of exactly N bytes: header only, no error
    send_len(2);
    e0(32'h0000AABB, 4'h3);
    beat(32'hAABBEEFF, 4'hC, 1'b1);

    // N above W clamps to W
    send_len(7);
    e0(32'h01020304, 4'hF);
    beat(32'h01020304, 4'hF, 1'b1);

    // N=3 over three beats
    send_len(3);
    e0(32'h00A1A2A3, 4'h7);
    e1(32'hA4B1B2B3, 4'hF, 1'b0);
    e1(32'hB4C1C2EE, 4'hE, 1'b1);
    beat(32'hA1A2A3A4, 4'hF, 1'b0);
    beat(32'hB1B2B3B4, 4'hF, 1'b0);
    beat(32'hC1C2EEFF, 4'hC, 1'b1);

    // Random output stalls plus a 5-cycle payload block mid-packet
    stall_en = 1;
    send_len(2);
    e0(32'h0000AABB, 4'h3);
    e1(32'hCCDD1122, 4'hF, 1'b0);
    e1(32'h33445566, 4'hF, 1'b0);
    e1(32'h77880000, 4'hC, 1'b1);
    beat(32'hAABBCCDD, 4'hF, 1'b0);
    m01_block = 5;
    beat(32'h11223344, 4'hF, 1'b0);
    beat(32'h55667788, 4'hF, 1'b1);
    send_len(3);
    e0(32'h00A1A2A3, 4'h7);
    e1(32'hA4B1B2B3, 4'hF, 1'b0);
    e1(32'hB4C1C2EE, 4'hE, 1'b1);
    beat(32'hA1A2A3A4, 4'hF, 1'b0);
    beat(32'hB1B2B3B4, 4'hF, 1'b0);
    beat(32'hC1C2EEFF, 4'hC, 1'b1);
    pkt_two_beat();
    for (int i = 0; i < 200 && (exp0.size() != 0 || exp1.size() != 0); i++) @(posedge clk);
    stall_en = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-BODY, then a clean packet
    send_len(2);
    e0(32'h0000AABB, 4'h3);
    e1(32'hCCDD1122, 4'hF, 1'b0);
    beat(32'hAABBCCDD, 4'hF, 1'b0);
    beat(32'h11223344, 4'hF, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_m00_valid", 64'(bus.m00_axis_tvalid), 64'(0));
    chk("midrst_m01_valid", 64'(bus.m01_axis_tvalid), 64'(0));
    chk("midrst_s00_ready", 64'(bus.s00_axis_tready), 64'(1));
    chk("midrst_s01_ready", 64'(bus.s01_axis_tready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    pkt_two_beat();

    for (int i = 0; i < 200 && (exp0.size() != 0 || exp1.size() != 0 || exp_err != 0); i++)
      @(posedge clk);
    repeat (3) @(posedge clk);
    chk("m00_drained", 64'(exp0.size()), 64'(0));
    chk("m01_drained", 64'(exp1.size()), 64'(0));
    chk("err_drained", 64'(exp_err), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
